xprod_sched: RTL and testbench

- Shared cross-product engine with a request scheduler for the geometry blocks (fence sorter, inside test, future hull logic).
- Arbitrates round-robin between NUM_REQ requesters. Latches one triangle (origin, p1, p2) per grant.
- Sequences a single signed multiplier over two passes to compute (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
- Returns the result tagged with the requester id.

---
 rtl/xprod_sched.sv | 151 +++++++++++++++
 tb/tb_xprod_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xprod_sched.sv
// Round-robin scheduled cross-product engine: one shared signed multiplier, two passes per job.
// Optional XPROD_RSP_READY_EN adds rsp_ready and a HOLD state that back-pressures the response.
module xprod_sched #(
  parameter int NUM_REQ = 2,
  parameter int CW      = 11,
  parameter int IDW     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*6*CW-1:0]   pts,
`ifdef XPROD_RSP_READY_EN
  input  logic                      rsp_ready,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic signed [2*CW+2:0]    rsp_val,
  output logic                      rsp_nonneg,
  output logic                      busy
);

  localparam int PW = 6 * CW;
  localparam int DW = CW + 1;
  localparam int MW = 2 * DW;
  localparam int RW = 2 * CW + 3;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         job_id;
  logic [PW-1:0]          job_pts;
  logic signed [MW-1:0]   tmp;

  logic                   found;
  logic [IDW-1:0]         win;
  logic [PW-1:0]          win_pts;
  int                     idx;

  // Search upward from the requester after the last winner.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_pts = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + 1 + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (int'(win) == r) win_pts = pts[r*PW +: PW];
    end
  end

  logic signed [CW-1:0] x0, y0, x1, y1, x2, y2;
  assign x0 = job_pts[0*CW +: CW];
  assign y0 = job_pts[1*CW +: CW];
  assign x1 = job_pts[2*CW +: CW];
  assign y1 = job_pts[3*CW +: CW];
  assign x2 = job_pts[4*CW +: CW];
  assign y2 = job_pts[5*CW +: CW];

  logic signed [DW-1:0] dx1, dy2, dx2, dy1;
  assign dx1 = DW'(x1) - DW'(x0);
  assign dy2 = DW'(y2) - DW'(y0);
  assign dx2 = DW'(x2) - DW'(x0);
  assign dy1 = DW'(y1) - DW'(y0);

  logic signed [DW-1:0] mul_a, mul_b;
  logic signed [MW-1:0] prod;
  logic signed [RW-1:0] res;

  // The single multiplier; operands muxed by pass.
  assign prod = MW'(mul_a) * MW'(mul_b);
  assign res  = RW'(tmp) - RW'(prod);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_a     = dx1;
    mul_b     = dy2;
    case (state)
      IDLE: if (found) state_nxt = MUL1;
      MUL1: state_nxt = MUL2;
      MUL2: begin
        mul_a = dx2;
        mul_b = dy1;
`ifdef XPROD_RSP_READY_EN
        state_nxt = HOLD;
`else
        state_nxt = IDLE;
`endif
      end
      HOLD: begin
`ifdef XPROD_RSP_READY_EN
        if (rsp_ready) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_val    <= '0;
      rsp_nonneg <= 1'b0;
      rr_ptr     <= IDW'(NUM_REQ - 1);
      job_id     <= '0;
      job_pts    <= '0;
      tmp        <= '0;
    end else begin
      gnt <= '0;
`ifdef XPROD_RSP_READY_EN
      if (state == HOLD && rsp_ready) rsp_valid <= 1'b0;
`else
      rsp_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (found) begin
          gnt     <= NUM_REQ'(1) << win;
          job_pts <= win_pts;
          job_id  <= win;
          rr_ptr  <= win;
        end
        MUL1: tmp <= prod;
        MUL2: begin
          rsp_val    <= res;
          rsp_nonneg <= !res[RW-1];
          rsp_id     <= job_id;
          rsp_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xprod_sched.sv
// Directed checks of xprod_sched: arithmetic, arbitration order, reset abort, optional back-pressure.
module tb_xprod_sched;

  localparam int NUM_REQ = 2;
  localparam int CW      = 11;
  localparam int IDW     = 2;
  localparam int PW      = 6 * CW;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*PW-1:0]    pts;
  logic                     rsp_ready;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic signed [2*CW+2:0]   rsp_val;
  logic                     rsp_nonneg;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xprod_sched #(.NUM_REQ(NUM_REQ), .CW(CW), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .pts        (pts),
`ifdef XPROD_RSP_READY_EN
    .rsp_ready  (rsp_ready),
`endif
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_val    (rsp_val),
    .rsp_nonneg (rsp_nonneg),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [PW-1:0] mk_tri(input int x0, input int y0, input int x1,
                                           input int y1, input int x2, input int y2);
    return {11'(y2), 11'(x2), 11'(y1), 11'(x1), 11'(y0), 11'(x0)};
  endfunction

  task automatic set_pts(input int r, input logic [PW-1:0] v);
    pts[r*PW +: PW] = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    32'(gnt),        0);
    chk({tag, "_valid"},  32'(rsp_valid),  0);
    chk({tag, "_id"},     32'(rsp_id),     0);
    chk({tag, "_val"},    32'(rsp_val),    0);
    chk({tag, "_nonneg"}, 32'(rsp_nonneg), 0);
    chk({tag, "_busy"},   32'(busy),       0);
  endtask

  // Single requester job from IDLE; checks grant, latency and the result.
  task automatic run_job(input string tag, input int r, input logic [PW-1:0] tri_v,
                         input int ev, input int enn);
    set_pts(r, tri_v);
    req[r] = 1'b1;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << r));
    chk({tag, "_busy"}, 32'(busy), 1);
    req[r] = 1'b0;
    tick();
    chk({tag, "_gnt_pulse"}, 32'(gnt), 0);
    chk({tag, "_early"}, 32'(rsp_valid), 0);
    tick();
    chk({tag, "_valid"},  32'(rsp_valid),  1);
    chk({tag, "_id"},     32'(rsp_id),     32'(r));
    chk({tag, "_val"},    32'(rsp_val),    32'(ev));
    chk({tag, "_nonneg"}, 32'(rsp_nonneg), 32'(enn));
    tick();
    chk({tag, "_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    pts       = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    run_job("t1",     0, mk_tri(0, 0, 4, 0, 0, 3), 12, 1);
    run_job("t2sw",   0, mk_tri(0, 0, 0, 3, 4, 0), -12, 0);
    run_job("t2col",  0, mk_tri(0, 0, 1, 1, 2, 2), 0, 1);
    run_job("t3max",  1, mk_tri(-1024, -1024, 1023, -1024, -1024, 1023), 4190209, 1);
    run_job("t3min",  1, mk_tri(-1024, -1024, -1024, 1023, 1023, -1024), -4190209, 0);

    // Both requesting continuously from reset: strict alternation, 3-cycle spacing.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_pts(0, mk_tri(0, 0, 4, 0, 0, 3));
    set_pts(1, mk_tri(0, 0, 0, 3, 4, 0));
    req = 2'b11;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("t4_gnt%0d", j), 32'(gnt), (j % 2 == 0) ? 1 : 2);
      tick();
      tick();
      chk($sformatf("t4_valid%0d", j), 32'(rsp_valid), 1);
      chk($sformatf("t4_id%0d", j), 32'(rsp_id), 32'(j % 2));
      chk($sformatf("t4_val%0d", j), 32'(rsp_val), (j % 2 == 0) ? 12 : -12);
`ifdef XPROD_RSP_READY_EN
      tick();
`endif
    end
    req = 2'b00;
    tick();
    tick();

    // Reset during MUL1 aborts the job and restores requester-0 priority.
    set_pts(0, mk_tri(0, 0, 4, 0, 0, 3));
    req = 2'b01;
    tick();
    chk("t5_gnt", 32'(gnt), 1);
    req = 2'b00;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_reset_outputs("t5");
    tick();
    chk("t5_novalid1", 32'(rsp_valid), 0);
    tick();
    chk("t5_novalid2", 32'(rsp_valid), 0);
    req = 2'b11;
    tick();
    chk("t5_prio", 32'(gnt), 1);
    req = 2'b00;
    tick();
    tick();
    chk("t5_valid", 32'(rsp_valid), 1);
    chk("t5_id",    32'(rsp_id),    0);
    chk("t5_val",   32'(rsp_val),   12);
    tick();

`ifdef XPROD_RSP_READY_EN
    set_pts(0, mk_tri(0, 0, 4, 0, 0, 3));
    set_pts(1, mk_tri(0, 0, 1, 1, 2, 2));
    req = 2'b01;
    rsp_ready = 1'b0;
    tick();
    chk("t6_gnt0", 32'(gnt), 1);
    req = 2'b10;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t6_hold_valid%0d", c), 32'(rsp_valid), 1);
      chk($sformatf("t6_hold_val%0d", c),   32'(rsp_val),   12);
      chk($sformatf("t6_hold_id%0d", c),    32'(rsp_id),    0);
      chk($sformatf("t6_hold_busy%0d", c),  32'(busy),      1);
      tick();
      chk($sformatf("t6_nogrant%0d", c),    32'(gnt),       0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t6_drop",    32'(rsp_valid), 0);
    chk("t6_drop_gnt", 32'(gnt),      0);
    tick();
    chk("t6_gnt1", 32'(gnt), 2);
    req = 2'b00;
    tick();
    tick();
    chk("t6_valid1", 32'(rsp_valid), 1);
    chk("t6_id1",    32'(rsp_id),    1);
    chk("t6_val1",   32'(rsp_val),   0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
